// File: rtl/float_add_pipe.sv
// Floating-point add/subtract: S1 unpack/align, S2 signed mantissa add, S3 normalise/round/pack.
// Latency: 3 cycles from an accepted request to resp_valid; one result per cycle when not stalled.
// Backpressure: resp_valid && !resp_ready freezes every stage, and req_ready = !stall.
// Build option: define FLOAT_ADD_PIPE_ROUND_EN for round-to-nearest-even; otherwise guard bits are truncated.
module float_add_pipe #(
    parameter int float_exp_width  = 8,
    parameter int float_mant_width = 23
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [float_exp_width+float_mant_width:0] a,
    input  logic [float_exp_width+float_mant_width:0] b,
    input  logic                                      sub,
    output logic                                      resp_valid,
    input  logic                                      resp_ready,
    output logic [float_exp_width+float_mant_width:0] out
);

    localparam int EW   = float_exp_width;
    localparam int MW   = float_mant_width;
    localparam int W    = 1 + EW + MW;
    localparam int SW   = MW + 4;          // hidden 1, mantissa, guard, round, sticky
    localparam int AW   = SW + 2;          // plus carry and sign for the two's-complement add
    localparam int MAGW = AW - 1;          // magnitude of the sum, carry bit on top
    localparam int SIGW = MW + 1;          // normalised significand without guard bits
    localparam int EP   = EW + 2;          // signed exponent work width
    localparam int LZW  = $clog2(SW + 1);
    localparam int unsigned SH_MAX = MW + 3;
    localparam logic signed [EP-1:0] EXP_ZERO = '0;
    localparam logic signed [EP-1:0] EXP_INF  = EP'((1 << EW) - 1);

    // Sign-magnitude to two's complement with room for the carry
    function automatic logic signed [AW-1:0] to_twos(input logic neg, input logic [SW-1:0] mag);
        logic signed [AW-1:0] v;
        v = $signed({2'b00, mag});
        return neg ? -v : v;
    endfunction

    // Count leading zeros from the hidden-bit position downwards
    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n     = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic w_stall;

    // ---------------- S1: unpack and align ----------------
    logic          w_sa, w_sb, w_a_zero, w_b_zero, w_a_big;
    logic          w_sign_big, w_sign_small;
    logic [EW-1:0] w_ea, w_eb, w_exp_big, w_diff;
    logic [MW-1:0] w_ma, w_mb, w_m_big, w_m_small;
    logic [SW-1:0] w_sig_big, w_sig_small_raw, w_lost_mask, w_sig_small;
    logic          w_byp;
    logic [W-1:0]  w_byp_word;

    logic                 r1_vld;
    logic [EW-1:0]        r1_exp;
    logic signed [AW-1:0] r1_op_big, r1_op_small;
    logic                 r1_byp;
    logic [W-1:0]         r1_byp_word;

    // Pick the larger exponent, right-shift the other significand and fold shifted-out bits into sticky
    always_comb begin
        w_sa     = a[W-1];
        w_sb     = b[W-1] ^ sub;
        w_ea     = a[W-2:MW];
        w_eb     = b[W-2:MW];
        w_ma     = a[MW-1:0];
        w_mb     = b[MW-1:0];
        w_a_zero = (w_ea == '0);
        w_b_zero = (w_eb == '0);
        w_a_big  = (w_ea >= w_eb);
        if (w_a_big) begin
            w_exp_big    = w_ea;
            w_diff       = w_ea - w_eb;
            w_m_big      = w_ma;
            w_m_small    = w_mb;
            w_sign_big   = w_sa;
            w_sign_small = w_sb;
        end else begin
            w_exp_big    = w_eb;
            w_diff       = w_eb - w_ea;
            w_m_big      = w_mb;
            w_m_small    = w_ma;
            w_sign_big   = w_sb;
            w_sign_small = w_sa;
        end
        w_sig_big       = {1'b1, w_m_big, 3'b000};
        w_sig_small_raw = {1'b1, w_m_small, 3'b000};
        w_lost_mask     = ~({SW{1'b1}} << w_diff);
        w_sig_small     = w_sig_small_raw >> w_diff;
        if (32'(w_diff) > SH_MAX) begin
            // Everything shifted past the sticky position: only its non-zero-ness survives
            w_sig_small = {{(SW-1){1'b0}}, 1'b1};
        end else begin
            w_sig_small[0] = w_sig_small[0] | (|(w_sig_small_raw & w_lost_mask));
        end
        // A zero (or flushed denormal) operand makes the result the other operand, effective sign applied
        w_byp = w_a_zero | w_b_zero;
        if (w_a_zero) begin
            w_byp_word = w_b_zero ? {w_sb, {(W-1){1'b0}}} : {w_sb, b[W-2:0]};
        end else begin
            w_byp_word = a;
        end
    end

    // S1 register: aligned signed operands plus the zero-operand bypass word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_vld      <= 1'b0;
            r1_exp      <= '0;
            r1_op_big   <= '0;
            r1_op_small <= '0;
            r1_byp      <= 1'b0;
            r1_byp_word <= '0;
        end else if (!w_stall) begin
            r1_vld      <= req_valid;
            r1_exp      <= w_exp_big;
            r1_op_big   <= to_twos(w_sign_big, w_sig_big);
            r1_op_small <= to_twos(w_sign_small, w_sig_small);
            r1_byp      <= w_byp;
            r1_byp_word <= w_byp_word;
        end
    end

    // ---------------- S2: signed add ----------------
    logic signed [AW-1:0] w2_sum;
    logic [MAGW-1:0]      w2_mag;

    logic            r2_vld;
    logic            r2_sign;
    logic [MAGW-1:0] r2_mag;
    logic [EW-1:0]   r2_exp;
    logic            r2_byp;
    logic [W-1:0]    r2_byp_word;

    // Add the aligned operands and split the sum back into sign and magnitude
    always_comb begin
        w2_sum = r1_op_big + r1_op_small;
        w2_mag = w2_sum[AW-1] ? MAGW'(-w2_sum) : w2_sum[AW-2:0];
    end

    // S2 register: result sign, unnormalised magnitude, reference exponent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_vld      <= 1'b0;
            r2_sign     <= 1'b0;
            r2_mag      <= '0;
            r2_exp      <= '0;
            r2_byp      <= 1'b0;
            r2_byp_word <= '0;
        end else if (!w_stall) begin
            r2_vld      <= r1_vld;
            r2_sign     <= w2_sum[AW-1];
            r2_mag      <= w2_mag;
            r2_exp      <= r1_exp;
            r2_byp      <= r1_byp;
            r2_byp_word <= r1_byp_word;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic                 r3_vld;
    logic [W-1:0]         r3_word;

    logic signed [EP-1:0] w3_exp_in, w3_exp_n, w3_exp_f;
    logic [LZW-1:0]       w3_lz;
    logic [SW-1:0]        w3_norm;
    logic [SIGW-1:0]      w3_sig;
    logic [MW-1:0]        w3_mant;
    logic [W-1:0]         w3_word;
`ifdef FLOAT_ADD_PIPE_ROUND_EN
    logic                 w3_up;
    logic [SIGW:0]        w3_sig_r;
`endif

    // Bring the hidden bit back to the top, then round or truncate and clamp the exponent range
    always_comb begin
        w3_exp_in = $signed(EP'(r2_exp));
        w3_lz     = '0;
        if (r2_mag[SW]) begin
            // Carry out of the add: one right shift, keep the dropped bit in sticky
            w3_norm  = {r2_mag[SW:2], r2_mag[1] | r2_mag[0]};
            w3_exp_n = w3_exp_in + EP'(1);
        end else begin
            w3_lz    = lzc(r2_mag[SW-1:0]);
            w3_norm  = r2_mag[SW-1:0] << w3_lz;
            w3_exp_n = w3_exp_in - $signed(EP'(w3_lz));
        end
        w3_sig = SIGW'(w3_norm >> 3);
`ifdef FLOAT_ADD_PIPE_ROUND_EN
        w3_up    = w3_norm[2] & (w3_norm[1] | w3_norm[0] | w3_sig[0]);
        w3_sig_r = {1'b0, w3_sig} + (SIGW+1)'(w3_up);
        if (w3_sig_r[SIGW]) begin
            // Rounding rolled 1.11..1 over to 10.00..0
            w3_mant  = w3_sig_r[SIGW-1:1];
            w3_exp_f = w3_exp_n + EP'(1);
        end else begin
            w3_mant  = w3_sig_r[MW-1:0];
            w3_exp_f = w3_exp_n;
        end
`else
        w3_mant  = MW'(w3_sig);
        w3_exp_f = w3_exp_n;
`endif
        if (r2_byp) begin
            w3_word = r2_byp_word;
        end else if (r2_mag == '0) begin
            w3_word = '0;
        end else if (w3_exp_f <= EXP_ZERO) begin
            w3_word = {r2_sign, {(W-1){1'b0}}};
        end else if (w3_exp_f >= EXP_INF) begin
            w3_word = {r2_sign, {EW{1'b1}}, {MW{1'b0}}};
        end else begin
            w3_word = {r2_sign, w3_exp_f[EW-1:0], w3_mant};
        end
    end

    // S3 register: the visible result, frozen while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_vld  <= 1'b0;
            r3_word <= '0;
        end else if (!w_stall) begin
            r3_vld  <= r2_vld;
            r3_word <= w3_word;
        end
    end

    assign w_stall    = r3_vld & ~resp_ready;
    assign req_ready  = ~w_stall;
    assign resp_valid = r3_vld;
    assign out        = r3_word;

endmodule
